cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
Exception/interrupt sequencer and write-port arbiter for the CP0 register file. Owns the single CP0 write port and shares it between pipeline MTC0 writes and its own multi-cycle exception-entry and ERET sequences. Drives pipeline stall/flush and PC redirect.

Parameters:
EXC_VECTOR, 32'h0000_0180, redirect PC on exception or interrupt entry.
EPC_ADDR, 14, CP0 register number of EPC.
CAUSE_ADDR, 13, CP0 register number of Cause.
STATUS_ADDR, 12, CP0 register number of Status.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
mtc0_req  in  1  pipeline requests a CP0 write
mtc0_addr  in  5  MTC0 register number
mtc0_sel  in  6  MTC0 select
mtc0_data  in  32  MTC0 write data
mtc0_ack  out  1  MTC0 write accepted this cycle
exc_req  in  1  synchronous exception from pipeline
exc_code  in  5  ExcCode
exc_pc  in  32  PC of faulting instruction
exc_bd  in  1  faulting instruction is in a delay slot
exc_badva  in  32  faulting address (used only with option)
eret_req  in  1  ERET executing
int_in  in  6  asynchronous hardware interrupt lines
status_in  in  32  current Status from CP0
epc_in  in  32  current EPC from CP0
cp0_addr  out  5  CP0 write address
cp0_sel  out  6  CP0 write select
cp0_din  out  32  CP0 write data
cp0_write  out  1  CP0 write strobe
stall  out  1  freeze pipeline
flush  out  1  kill in-flight instructions
redirect_valid  out  1  load redirect_pc into PC
redirect_pc  out  32  redirect target

Behaviour:
- All outputs registered except mtc0_ack, which is combinational. During reset, all outputs read 0 and state is IDLE; the interrupt synchronizer is cleared.
- int_in passes through a 2-flop synchronizer giving int_s. int_pend = status_in[0] & ~status_in[1] & |(int_s & status_in[15:10]).
- Events are sampled only in IDLE. Priority: exc_req > eret_req > int_pend > mtc0_req.
- MTC0 is granted only in IDLE with no higher event pending. When granted, mtc0_ack=1 and cp0_write/addr/sel/din are driven the next cycle for exactly 1 cycle. A request that is not acked must be held by the pipeline.
- On exc/int entry, the following are latched: code (interrupt uses 0), EPC value, BD bit, int_s, and status_in. EPC value is exc_pc-4 if exc_bd, else exc_pc. For interrupts, exc_pc is the resumption PC and exc_bd=0.
- Exception entry FSM: IDLE -> W_EPC -> W_CAUSE -> W_STATUS -> REDIR -> IDLE.
  - W_EPC writes EPC_ADDR with the EPC value.
  - W_CAUSE writes CAUSE_ADDR with {BD,15'b0,int_s,3'b0,code,2'b0}.
  - W_STATUS writes STATUS_ADDR with latched status|32'h2 (EXL=1).
  - REDIR asserts redirect_valid=1, redirect_pc=EXC_VECTOR, and flush=1 for 1 cycle.
  - All writes use cp0_sel=0.
- ERET FSM: IDLE -> E_STATUS -> REDIR -> IDLE. epc_in is latched on entry. E_STATUS writes latched status & ~32'h2. REDIR targets the latched EPC.
- stall=1 in every non-IDLE state, including REDIR. The cycle after REDIR is IDLE with stall=0.
- Exception entry latency from exc_req to redirect_valid is 4 cycles. ERET latency is 2 cycles.
- Requests arriving in a non-IDLE state are ignored. The pipeline is stalled/flushed, so they are re-presented if still valid.
- Simultaneous exc_req and eret_req: the exception wins and ERET is dropped.
- Reset asserted mid-sequence aborts immediately. The partial CP0 writes already performed stand.

Optional Feature:
CP0_BADVADDR_EN. When defined, exc_code 4 or 5 (AdEL/AdES) inserts state W_BADVA between W_EPC and W_CAUSE, writing CP0 reg 8 with exc_badva latched at entry. This raises latency to 5 cycles. When undefined, exc_badva is unused, W_BADVA does not exist, and latency is always 4.

Test Plan:
- Reset release, then mtc0_req to addr 12 with data 32'h0000FC01 -> mtc0_ack same cycle; next cycle cp0_write=1, addr=12, din=32'h0000FC01 for 1 cycle.
- exc_req, code 8, exc_pc=32'h00400020, bd=0, status_in=32'h0000FC01 -> successive writes 14←00400020, 13←00000020, 12←0000FC03; then redirect_pc=00000180 with flush; stall 4 cycles.
- Same as above with bd=1 -> EPC written 0040001C and Cause bit31=1.
- status_in=32'h00000401, int_in[0] pulsed -> after sync, entry with Cause=00000400. With status_in[1]=1, no entry occurs.
- ERET with epc_in=32'h00400024, status_in=32'h0000FC03 -> 12←0000FC01; redirect_pc=00400024 after 2 cycles.
- exc_req, eret_req, and mtc0_req in the same cycle -> exception sequence runs, mtc0_ack=0 throughout, no ERET write. With CP0_BADVADDR_EN and code 4 -> an extra write 8←exc_badva occurs after the EPC write.

Source files
------------

// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline <-> CP0 exception controller bundle: MTC0 requests, exception/ERET/interrupt
// inputs, the shared CP0 write port, and pipeline stall/flush/redirect controls.
interface cp0_exc_ctrl_if;
  logic        mtc0_req;
  logic [4:0]  mtc0_addr;
  logic [5:0]  mtc0_sel;
  logic [31:0] mtc0_data;
  logic        mtc0_ack;

  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badva;
  logic        eret_req;
  logic [5:0]  int_in;
  logic [31:0] status_in;
  logic [31:0] epc_in;

  logic [4:0]  cp0_addr;
  logic [5:0]  cp0_sel;
  logic [31:0] cp0_din;
  logic        cp0_write;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mtc0_req, mtc0_addr, mtc0_sel, mtc0_data,
    output exc_req, exc_code, exc_pc, exc_bd, exc_badva, eret_req, int_in, status_in, epc_in,
    input  mtc0_ack, cp0_addr, cp0_sel, cp0_din, cp0_write,
    input  stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  mtc0_req, mtc0_addr, mtc0_sel, mtc0_data,
    input  exc_req, exc_code, exc_pc, exc_bd, exc_badva, eret_req, int_in, status_in, epc_in,
    output mtc0_ack, cp0_addr, cp0_sel, cp0_din, cp0_write,
    output stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer and single write-port arbiter (MTC0 vs. entry/ERET).
// Optional feature macro: CP0_BADVADDR_EN (adds a BadVAddr write for AdEL/AdES entries).
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0180,
  parameter logic [4:0]  EPC_ADDR    = 5'd14,
  parameter logic [4:0]  CAUSE_ADDR  = 5'd13,
  parameter logic [4:0]  STATUS_ADDR = 5'd12
) (
  input logic            clk,
  input logic            rst,
  cp0_exc_ctrl_if.slave  bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] W_EPC    = 3'd1;
  localparam logic [2:0] W_CAUSE  = 3'd2;
  localparam logic [2:0] W_STATUS = 3'd3;
  localparam logic [2:0] E_STATUS = 3'd4;
  localparam logic [2:0] REDIR    = 3'd5;
`ifdef CP0_BADVADDR_EN
  localparam logic [2:0] W_BADVA    = 3'd6;
  localparam logic [4:0] BADVA_ADDR = 5'd8;
`endif

  logic [2:0]  state, state_nxt;
  logic [5:0]  int_meta, int_s;
  logic        int_pend, take_exc, take_eret, take_int;

  logic [4:0]  lat_code,   lat_code_nxt;
  logic        lat_bd,     lat_bd_nxt;
  logic [5:0]  lat_ip,     lat_ip_nxt;
  logic [31:0] lat_epc,    lat_epc_nxt;
  logic [31:0] lat_status, lat_status_nxt;
  logic [31:0] lat_target, lat_target_nxt;
`ifdef CP0_BADVADDR_EN
  logic [31:0] lat_badva,  lat_badva_nxt;
`else
  logic        unused_badva;
  assign unused_badva = ^bus.exc_badva;
`endif

  logic        wr_nxt, redir_nxt;
  logic [4:0]  addr_nxt;
  logic [5:0]  sel_nxt;
  logic [31:0] din_nxt, rpc_nxt;

  assign int_pend  = bus.status_in[0] & ~bus.status_in[1] & (|(int_s & bus.status_in[15:10]));
  assign take_exc  = (state == IDLE) & bus.exc_req;
  assign take_eret = (state == IDLE) & ~bus.exc_req & bus.eret_req;
  assign take_int  = (state == IDLE) & ~bus.exc_req & ~bus.eret_req & int_pend;

  // Lowest priority: the write port goes to MTC0 only when nothing else wants it.
  assign bus.mtc0_ack = rst & (state == IDLE) & bus.mtc0_req
                      & ~bus.exc_req & ~bus.eret_req & ~int_pend;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt      = state;
    lat_code_nxt   = lat_code;
    lat_bd_nxt     = lat_bd;
    lat_ip_nxt     = lat_ip;
    lat_epc_nxt    = lat_epc;
    lat_status_nxt = lat_status;
    lat_target_nxt = lat_target;
`ifdef CP0_BADVADDR_EN
    lat_badva_nxt  = lat_badva;
`endif
    case (state)
      IDLE: begin
        if (take_exc) begin
          state_nxt      = W_EPC;
          lat_code_nxt   = bus.exc_code;
          lat_bd_nxt     = bus.exc_bd;
          lat_epc_nxt    = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
          lat_ip_nxt     = int_s;
          lat_status_nxt = bus.status_in;
          lat_target_nxt = EXC_VECTOR;
`ifdef CP0_BADVADDR_EN
          lat_badva_nxt  = bus.exc_badva;
`endif
        end else if (take_eret) begin
          state_nxt      = E_STATUS;
          lat_status_nxt = bus.status_in;
          lat_target_nxt = bus.epc_in;
        end else if (take_int) begin
          // exc_pc is the resumption PC here, never a delay-slot instruction.
          state_nxt      = W_EPC;
          lat_code_nxt   = 5'd0;
          lat_bd_nxt     = 1'b0;
          lat_epc_nxt    = bus.exc_pc;
          lat_ip_nxt     = int_s;
          lat_status_nxt = bus.status_in;
          lat_target_nxt = EXC_VECTOR;
        end
      end
`ifdef CP0_BADVADDR_EN
      W_EPC:    state_nxt = (lat_code == 5'd4 || lat_code == 5'd5) ? W_BADVA : W_CAUSE;
      W_BADVA:  state_nxt = W_CAUSE;
`else
      W_EPC:    state_nxt = W_CAUSE;
`endif
      W_CAUSE:  state_nxt = W_STATUS;
      W_STATUS: state_nxt = REDIR;
      E_STATUS: state_nxt = REDIR;
      REDIR:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered with it.
  always_comb begin
    wr_nxt    = 1'b0;
    addr_nxt  = 5'd0;
    sel_nxt   = 6'd0;
    din_nxt   = 32'd0;
    redir_nxt = 1'b0;
    rpc_nxt   = 32'd0;
    case (state_nxt)
      IDLE: begin
        if (bus.mtc0_ack) begin
          wr_nxt   = 1'b1;
          addr_nxt = bus.mtc0_addr;
          sel_nxt  = bus.mtc0_sel;
          din_nxt  = bus.mtc0_data;
        end
      end
      W_EPC: begin
        wr_nxt   = 1'b1;
        addr_nxt = EPC_ADDR;
        din_nxt  = lat_epc_nxt;
      end
`ifdef CP0_BADVADDR_EN
      W_BADVA: begin
        wr_nxt   = 1'b1;
        addr_nxt = BADVA_ADDR;
        din_nxt  = lat_badva_nxt;
      end
`endif
      W_CAUSE: begin
        wr_nxt   = 1'b1;
        addr_nxt = CAUSE_ADDR;
        din_nxt  = {lat_bd_nxt, 15'd0, lat_ip_nxt, 3'd0, lat_code_nxt, 2'd0};
      end
      W_STATUS: begin
        wr_nxt   = 1'b1;
        addr_nxt = STATUS_ADDR;
        din_nxt  = lat_status_nxt | 32'h0000_0002;
      end
      E_STATUS: begin
        wr_nxt   = 1'b1;
        addr_nxt = STATUS_ADDR;
        din_nxt  = lat_status_nxt & ~32'h0000_0002;
      end
      REDIR: begin
        redir_nxt = 1'b1;
        rpc_nxt   = lat_target_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_meta <= 6'd0;
      int_s    <= 6'd0;
    end else begin
      int_meta <= bus.int_in;
      int_s    <= int_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state              <= IDLE;
      lat_code           <= 5'd0;
      lat_bd             <= 1'b0;
      lat_ip             <= 6'd0;
      lat_epc            <= 32'd0;
      lat_status         <= 32'd0;
      lat_target         <= 32'd0;
`ifdef CP0_BADVADDR_EN
      lat_badva          <= 32'd0;
`endif
      bus.cp0_write      <= 1'b0;
      bus.cp0_addr       <= 5'd0;
      bus.cp0_sel        <= 6'd0;
      bus.cp0_din        <= 32'd0;
      bus.stall          <= 1'b0;
      bus.flush          <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= 32'd0;
    end else begin
      state              <= state_nxt;
      lat_code           <= lat_code_nxt;
      lat_bd             <= lat_bd_nxt;
      lat_ip             <= lat_ip_nxt;
      lat_epc            <= lat_epc_nxt;
      lat_status         <= lat_status_nxt;
      lat_target         <= lat_target_nxt;
`ifdef CP0_BADVADDR_EN
      lat_badva          <= lat_badva_nxt;
`endif
      bus.cp0_write      <= wr_nxt;
      bus.cp0_addr       <= addr_nxt;
      bus.cp0_sel        <= sel_nxt;
      bus.cp0_din        <= din_nxt;
      bus.stall          <= (state_nxt != IDLE);
      bus.flush          <= redir_nxt;
      bus.redirect_valid <= redir_nxt;
      bus.redirect_pc    <= rpc_nxt;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: vector table plus hand-written interrupt,
// held-MTC0 and mid-sequence reset sequences; CP0 writes/redirects go through a scoreboard.
module tb_cp0_exc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cp0_exc_ctrl_if bus();
  cp0_exc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef CP0_BADVADDR_EN
  localparam int ADEL_LAT = 5;
  localparam bit ADEL_BV  = 1'b1;
`else
  localparam int ADEL_LAT = 4;
  localparam bit ADEL_BV  = 1'b0;
`endif

  typedef struct {
    logic        redir;
    logic [4:0]  addr;
    logic [5:0]  sel;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    string       name;
    logic        mreq;
    logic [4:0]  maddr;
    logic [5:0]  msel;
    logic [31:0] mdata;
    logic        ereq;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] badva;
    logic        rreq;
    logic [31:0] status;
    logic [31:0] epc;
    logic        ack;
    int          lat;
    int          stalls;
    logic [31:0] e_epc;
    logic [31:0] e_cause;
    logic [31:0] e_status;
    logic [31:0] e_pc;
    logic        e_badva;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];
  ev_t  sb[$];
  ev_t  mon_e;
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_ev(input logic redir, input logic [4:0] addr, input logic [5:0] sel,
                         input logic [31:0] data);
    ev_t e;
    e.redir = redir; e.addr = addr; e.sel = sel; e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.mtc0_req = 1'b0;
    bus.exc_req  = 1'b0;
    bus.eret_req = 1'b0;
    bus.int_in   = 6'd0;
  endtask

  // Scoreboard consumer: every write strobe and every redirect must match the queue head.
  always @(negedge clk) begin
    if (rst && bus.cp0_write) begin
      if (sb.size() == 0) check("unexpected_write_addr", {27'd0, bus.cp0_addr}, 32'hFFFF_FFFF);
      else begin
        mon_e = sb.pop_front();
        check("wr_addr", {27'd0, bus.cp0_addr}, {27'd0, mon_e.addr});
        check("wr_sel",  {26'd0, bus.cp0_sel},  {26'd0, mon_e.sel});
        check("wr_din",  bus.cp0_din, mon_e.data);
      end
    end
    if (rst && bus.redirect_valid) begin
      if (sb.size() == 0) check("unexpected_redirect_pc", bus.redirect_pc, 32'hFFFF_FFFF);
      else begin
        mon_e = sb.pop_front();
        check("redir_event", {31'd0, mon_e.redir}, 32'd1);
        check("redir_pc",    bus.redirect_pc, mon_e.data);
        check("redir_flush", {31'd0, bus.flush}, 32'd1);
      end
    end
    if (rst && bus.flush && !bus.redirect_valid)
      check("flush_without_redirect", {31'd0, bus.redirect_valid}, 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   lat, stalls, first_wr, ack_cycle;
    logic [31:0] st_list[2];

    // name, mreq,maddr,msel,mdata, ereq,code,pc,bd,badva, rreq, status,epc,
    // ack,lat,stalls, e_epc,e_cause,e_status,e_pc,e_badva
    vecs[0] = '{"mtc0_status", 1'b1, 5'd12, 6'd0, 32'h0000FC01, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0,
                1'b0, 32'h0000FC01, 32'd0, 1'b1, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};
    vecs[1] = '{"mtc0_sel3", 1'b1, 5'd9, 6'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0,
                1'b0, 32'h0000FC01, 32'd0, 1'b1, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};
    vecs[2] = '{"exc_nobd", 1'b0, 5'd0, 6'd0, 32'd0, 1'b1, 5'd8, 32'h00400020, 1'b0, 32'd0,
                1'b0, 32'h0000FC01, 32'd0, 1'b0, 4, 4,
                32'h00400020, 32'h00000020, 32'h0000FC03, 32'h00000180, 1'b0};
    vecs[3] = '{"exc_bd", 1'b0, 5'd0, 6'd0, 32'd0, 1'b1, 5'd8, 32'h00400020, 1'b1, 32'd0,
                1'b0, 32'h0000FC01, 32'd0, 1'b0, 4, 4,
                32'h0040001C, 32'h80000020, 32'h0000FC03, 32'h00000180, 1'b0};
    vecs[4] = '{"eret", 1'b0, 5'd0, 6'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0,
                1'b1, 32'h0000FC03, 32'h00400024, 1'b0, 2, 2,
                32'd0, 32'd0, 32'h0000FC01, 32'h00400024, 1'b0};
    vecs[5] = '{"exc_eret_mtc0", 1'b1, 5'd12, 6'd0, 32'hFFFFFFFF, 1'b1, 5'd12, 32'h00400100, 1'b0,
                32'd0, 1'b1, 32'h00000011, 32'h00400500, 1'b0, 4, 4,
                32'h00400100, 32'h00000030, 32'h00000013, 32'h00000180, 1'b0};
    vecs[6] = '{"eret_mtc0", 1'b1, 5'd14, 6'd0, 32'h11111111, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0,
                1'b1, 32'h0000FF03, 32'h00400800, 1'b0, 2, 2,
                32'd0, 32'd0, 32'h0000FF01, 32'h00400800, 1'b0};
    vecs[7] = '{"exc_adel", 1'b0, 5'd0, 6'd0, 32'd0, 1'b1, 5'd4, 32'h00400200, 1'b0, 32'h12345678,
                1'b0, 32'h00000000, 32'd0, 1'b0, ADEL_LAT, ADEL_LAT,
                32'h00400200, 32'h00000010, 32'h00000002, 32'h00000180, ADEL_BV};

    drive_idle();
    bus.mtc0_addr = 5'd0; bus.mtc0_sel = 6'd0; bus.mtc0_data = 32'd0;
    bus.exc_code = 5'd0; bus.exc_pc = 32'd0; bus.exc_bd = 1'b0; bus.exc_badva = 32'd0;
    bus.status_in = 32'd0; bus.epc_in = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cp0_write", {31'd0, bus.cp0_write}, 32'd0);
    check("rst_cp0_addr",  {27'd0, bus.cp0_addr}, 32'd0);
    check("rst_cp0_din",   bus.cp0_din, 32'd0);
    check("rst_stall",     {31'd0, bus.stall}, 32'd0);
    check("rst_flush",     {31'd0, bus.flush}, 32'd0);
    check("rst_redirect",  {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_redir_pc",  bus.redirect_pc, 32'd0);
    check("rst_mtc0_ack",  {31'd0, bus.mtc0_ack}, 32'd0);
    rst = 1'b1;
    tick();

    // Vector table: one request cycle, then ten cycles of observation
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      bus.mtc0_req = v.mreq; bus.mtc0_addr = v.maddr; bus.mtc0_sel = v.msel; bus.mtc0_data = v.mdata;
      bus.exc_req = v.ereq; bus.exc_code = v.code; bus.exc_pc = v.pc; bus.exc_bd = v.bd;
      bus.exc_badva = v.badva; bus.eret_req = v.rreq; bus.status_in = v.status; bus.epc_in = v.epc;
      if (v.ereq) begin
        push_ev(1'b0, 5'd14, 6'd0, v.e_epc);
        if (v.e_badva) push_ev(1'b0, 5'd8, 6'd0, v.badva);
        push_ev(1'b0, 5'd13, 6'd0, v.e_cause);
        push_ev(1'b0, 5'd12, 6'd0, v.e_status);
        push_ev(1'b1, 5'd0, 6'd0, v.e_pc);
      end else if (v.rreq) begin
        push_ev(1'b0, 5'd12, 6'd0, v.e_status);
        push_ev(1'b1, 5'd0, 6'd0, v.e_pc);
      end else if (v.mreq) begin
        push_ev(1'b0, v.maddr, v.msel, v.mdata);
      end
      #1;
      check({v.name, "_ack"}, {31'd0, bus.mtc0_ack}, {31'd0, v.ack});
      lat = 0; stalls = 0; first_wr = 0;
      for (int t = 1; t <= 10; t++) begin
        tick();
        if (t == 1) drive_idle();
        if (bus.redirect_valid && lat == 0) lat = t;
        if (bus.stall) stalls++;
        if (bus.cp0_write && first_wr == 0) first_wr = t;
      end
      check({v.name, "_latency"}, lat, v.lat);
      check({v.name, "_stall_cycles"}, stalls, v.stalls);
      check({v.name, "_first_write_cycle"}, first_wr, 32'd1);
      check({v.name, "_drained"}, sb.size(), 32'd0);
    end

    // Interrupt through the synchronizer: pulse int_in[0] for one cycle
    bus.status_in = 32'h00000401; bus.exc_pc = 32'h00400040; bus.exc_bd = 1'b0;
    push_ev(1'b0, 5'd14, 6'd0, 32'h00400040);
    push_ev(1'b0, 5'd13, 6'd0, 32'h00000400);
    push_ev(1'b0, 5'd12, 6'd0, 32'h00000403);
    push_ev(1'b1, 5'd0, 6'd0, 32'h00000180);
    bus.int_in = 6'b000001;
    lat = 0; stalls = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 1) bus.int_in = 6'd0;
      if (bus.redirect_valid && lat == 0) lat = t;
      if (bus.stall) stalls++;
    end
    check("int_latency", lat, 32'd6);
    check("int_stall_cycles", stalls, 32'd4);
    check("int_drained", sb.size(), 32'd0);

    // Masked interrupts: EXL set, then IE clear -- no entry at all
    st_list[0] = 32'h00000403;
    st_list[1] = 32'h00000400;
    for (int k = 0; k < 2; k++) begin
      bus.status_in = st_list[k];
      bus.int_in = 6'b000001;
      stalls = 0;
      for (int t = 1; t <= 10; t++) begin
        tick();
        if (t == 1) bus.int_in = 6'd0;
        if (bus.stall) stalls++;
      end
      check($sformatf("int_masked%0d_stall_cycles", k), stalls, 32'd0);
    end

    // MTC0 held across an exception: refused until the controller is back in IDLE
    bus.status_in = 32'h00000001;
    bus.exc_req = 1'b1; bus.exc_code = 5'd8; bus.exc_pc = 32'h00400060; bus.exc_bd = 1'b0;
    bus.mtc0_req = 1'b1; bus.mtc0_addr = 5'd12; bus.mtc0_sel = 6'd0; bus.mtc0_data = 32'hAAAA0001;
    push_ev(1'b0, 5'd14, 6'd0, 32'h00400060);
    push_ev(1'b0, 5'd13, 6'd0, 32'h00000020);
    push_ev(1'b0, 5'd12, 6'd0, 32'h00000003);
    push_ev(1'b1, 5'd0, 6'd0, 32'h00000180);
    push_ev(1'b0, 5'd12, 6'd0, 32'hAAAA0001);
    #1;
    check("held_ack_cycle0", {31'd0, bus.mtc0_ack}, 32'd0);
    ack_cycle = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 1) bus.exc_req = 1'b0;
      if (bus.mtc0_ack) begin
        ack_cycle = t;
        break;
      end
    end
    check("held_ack_cycle", ack_cycle, 32'd5);
    check("held_ack_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.mtc0_req = 1'b0;
    repeat (3) tick();
    check("held_drained", sb.size(), 32'd0);

    // Reset in the middle of an exception entry: EPC and Cause writes stand, rest aborted
    bus.exc_req = 1'b1; bus.exc_code = 5'd8; bus.exc_pc = 32'h00400080; bus.exc_bd = 1'b0;
    push_ev(1'b0, 5'd14, 6'd0, 32'h00400080);
    push_ev(1'b0, 5'd13, 6'd0, 32'h00000020);
    tick();
    bus.exc_req = 1'b0;
    tick();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_cp0_write", {31'd0, bus.cp0_write}, 32'd0);
    check("abort_stall",     {31'd0, bus.stall}, 32'd0);
    check("abort_cp0_din",   bus.cp0_din, 32'd0);
    tick();
    rst = 1'b1;
    stalls = 0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (bus.stall) stalls++;
    end
    check("abort_stall_after", stalls, 32'd0);
    check("abort_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
